fsm_dispatch: RTL and testbench

//  Top-level control sequencer, directly upstream of the combined execute FSM.
//  - Fetches each instruction from memory into its own instruction register.
//  - Classifies the opcode and drives the one-hot start[2:0] (ALU / branch-jump / load-store).
//  - Holds start until the execute FSM reports done, then retires and loops to the next fetch.
//  - Traps on illegal opcodes and on execute watchdog timeout.

---
 rtl/fsm_dispatch.sv | 177 +++++++++++++++++
 tb/tb_fsm_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_dispatch.sv
// fsm_dispatch - top-level control sequencer feeding the combined execute FSM.
//
// Fetches one instruction per loop into an instruction register, classifies
// its opcode, raises a one-hot start for the matching execute unit and holds
// it until the execute FSM answers with done. Then it retires the instruction
// and either fetches the next one (run=1) or parks in IDLE. Illegal opcodes and
// a watchdog timeout in EXEC both end in a terminal TRAP state that only
// reset_n can leave.
//
// Parameters
//   COUNT_W       width of the retired-instruction counter (wraps)
//   DONE_TIMEOUT  max EXEC cycles before trapping; 0 disables the watchdog
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   run            level; 1 = keep fetching, 0 = stop at next boundary
//   mem_rdata      memory read data (fetched instruction)
//   memory_done    memory transaction complete pulse
//   done           execute-FSM completion pulse
//   insn           instruction register
//   start          one-hot execute select: 001 ALU, 010 branch/jump, 100 load/store
//   memory_start   one-cycle fetch request
//   sel_mem_fetch  memory address/op muxed to the PC instruction read
//   busy           high in every state except IDLE and TRAP
//   illegal_insn   sticky illegal-opcode trap flag
//   timeout        sticky watchdog trap flag
//   retired        count of completed instructions

module fsm_dispatch #(
    parameter int COUNT_W      = 32,
    parameter int DONE_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [31:0]        mem_rdata,
    input  logic               memory_done,
    input  logic               done,
    output logic [31:0]        insn,
    output logic [2:0]         start,
    output logic               memory_start,
    output logic               sel_mem_fetch,
    output logic               busy,
    output logic               illegal_insn,
    output logic               timeout,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_TRAP
    } state_t;

    // Watchdog compare value; only meaningful when the watchdog is enabled.
    localparam logic [31:0] WD_LIMIT = (DONE_TIMEOUT > 0) ? 32'(DONE_TIMEOUT - 1) : 32'd0;

    state_t               state_q, state_d;
    logic [31:0]          insn_q, insn_d;
    logic [2:0]           start_q, start_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic [31:0]          watchdog_q, watchdog_d;

    logic [2:0]           dec_class;
    logic                 wd_expired;

    // Opcode classification; 000 marks an illegal opcode.
    always_comb begin
        dec_class = 3'b000;
        case (insn_q[6:0])
            7'b0110011, 7'b0010011, 7'b0111011,
            7'b0011011, 7'b0110111, 7'b0010111: dec_class = 3'b001;
            7'b1100011, 7'b1101111, 7'b1100111: dec_class = 3'b010;
            7'b0000011, 7'b0100011,
            7'b0000111, 7'b0100111:             dec_class = 3'b100;
            default:                            dec_class = 3'b000;
        endcase
    end

    generate
        if (DONE_TIMEOUT > 0) begin : g_wd_on
            assign wd_expired = (watchdog_q == WD_LIMIT);
        end else begin : g_wd_off
            assign wd_expired = 1'b0;
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            insn_q     <= '0;
            start_q    <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            retired_q  <= '0;
            watchdog_q <= '0;
        end else begin
            state_q    <= state_d;
            insn_q     <= insn_d;
            start_q    <= start_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            retired_q  <= retired_d;
            watchdog_q <= watchdog_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   if (memory_done) state_d = S_DECODE;
            S_DECODE: state_d = (dec_class == 3'b000) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (done)            state_d = run ? S_FETCH : S_IDLE;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered datapath.
    always_comb begin
        insn_d     = insn_q;
        start_d    = start_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        retired_d  = retired_q;
        watchdog_d = watchdog_q;
        case (state_q)
            S_WAIT: if (memory_done) insn_d = mem_rdata;
            S_DECODE: begin
                watchdog_d = '0;
                if (dec_class == 3'b000) illegal_d = 1'b1;
                else                     start_d   = dec_class;
            end
            S_EXEC: begin
                if (done) begin
                    start_d    = '0;
                    retired_d  = retired_q + COUNT_W'(1);
                    watchdog_d = '0;
                end else if (wd_expired) begin
                    start_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    watchdog_d = watchdog_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        memory_start  = (state_q == S_FETCH);
        sel_mem_fetch = (state_q == S_FETCH) || (state_q == S_WAIT);
        busy          = (state_q != S_IDLE) && (state_q != S_TRAP);
    end

    assign insn         = insn_q;
    assign start        = start_q;
    assign illegal_insn = illegal_q;
    assign timeout      = timeout_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_fsm_dispatch.sv
// Testbench for fsm_dispatch. Two instances share one input stream:
// u0 (COUNT_W=4, DONE_TIMEOUT=8) and u1 (COUNT_W=32, watchdog off).
// A phase-level reference model predicts every output of both each cycle;
// directed scenarios add literal expectations, then random traffic follows.

module tb_fsm_dispatch;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_WAIT = 2, PH_DECODE = 3, PH_EXEC = 4, PH_TRAP = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        memory_done = 1'b0;
    logic        done = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] insn0, insn1;
    logic [2:0]  start0, start1;
    logic        ms0, ms1, sel0, sel1, busy0, busy1, ill0, ill1, to0, to1;
    logic [3:0]  ret0;
    logic [31:0] ret1;

    fsm_dispatch #(.COUNT_W(4), .DONE_TIMEOUT(8)) u0 (
        .clk(clk), .reset_n(reset_n), .run(run), .mem_rdata(mem_rdata),
        .memory_done(memory_done), .done(done), .insn(insn0), .start(start0),
        .memory_start(ms0), .sel_mem_fetch(sel0), .busy(busy0),
        .illegal_insn(ill0), .timeout(to0), .retired(ret0)
    );

    fsm_dispatch #(.COUNT_W(32), .DONE_TIMEOUT(0)) u1 (
        .clk(clk), .reset_n(reset_n), .run(run), .mem_rdata(mem_rdata),
        .memory_done(memory_done), .done(done), .insn(insn1), .start(start1),
        .memory_start(ms1), .sel_mem_fetch(sel1), .busy(busy1),
        .illegal_insn(ill1), .timeout(to1), .retired(ret1)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] ALU_OPS [6] = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111, 7'b0010111};
    logic [6:0] BR_OPS  [3] = '{7'b1100011, 7'b1101111, 7'b1100111};
    logic [6:0] LS_OPS  [4] = '{7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111};

    function automatic logic [2:0] classify(input logic [6:0] op);
        foreach (ALU_OPS[i]) if (ALU_OPS[i] == op) return 3'b001;
        foreach (BR_OPS[i])  if (BR_OPS[i] == op)  return 3'b010;
        foreach (LS_OPS[i])  if (LS_OPS[i] == op)  return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [6:0] pick_legal();
        int r;
        r = int'($urandom_range(0, 12));
        if (r < 6)  return ALU_OPS[r];
        if (r < 9)  return BR_OPS[r - 6];
        return LS_OPS[r - 9];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          TO_CYC [2] = '{8, 0};
    logic [31:0] RMASK  [2] = '{32'h0000_000F, 32'hFFFF_FFFF};

    int          m_ph    [2] = '{PH_IDLE, PH_IDLE};
    logic [31:0] m_insn  [2] = '{32'd0, 32'd0};
    logic [2:0]  m_start [2] = '{3'd0, 3'd0};
    logic        m_ill   [2] = '{1'b0, 1'b0};
    logic        m_to    [2] = '{1'b0, 1'b0};
    logic [31:0] m_ret   [2] = '{32'd0, 32'd0};
    int          m_execn [2] = '{0, 0};   // EXEC cycles already spent on this instruction

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_ph[k] <= PH_IDLE; m_insn[k] <= '0; m_start[k] <= '0;
                m_ill[k] <= 1'b0; m_to[k] <= 1'b0; m_ret[k] <= '0; m_execn[k] <= 0;
            end else begin
                case (m_ph[k])
                    PH_IDLE:  if (run) m_ph[k] <= PH_FETCH;
                    PH_FETCH: m_ph[k] <= PH_WAIT;
                    PH_WAIT:  if (memory_done) begin
                        m_insn[k] <= mem_rdata;
                        m_ph[k]   <= PH_DECODE;
                    end
                    PH_DECODE: begin
                        m_execn[k] <= 0;
                        if (classify(m_insn[k][6:0]) == 3'b000) begin
                            m_ill[k] <= 1'b1;
                            m_ph[k]  <= PH_TRAP;
                        end else begin
                            m_start[k] <= classify(m_insn[k][6:0]);
                            m_ph[k]    <= PH_EXEC;
                        end
                    end
                    PH_EXEC: begin
                        if (done) begin
                            m_start[k] <= '0;
                            m_ret[k]   <= (m_ret[k] + 32'd1) & RMASK[k];
                            m_ph[k]    <= run ? PH_FETCH : PH_IDLE;
                        end else if (TO_CYC[k] > 0 && m_execn[k] + 1 == TO_CYC[k]) begin
                            m_start[k] <= '0;
                            m_to[k]    <= 1'b1;
                            m_ph[k]    <= PH_TRAP;
                        end else begin
                            m_execn[k] <= m_execn[k] + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic cmp_one(input int k, input logic [31:0] a_insn, input logic [2:0] a_start,
                           input logic a_ms, input logic a_sel, input logic a_busy,
                           input logic a_ill, input logic a_to, input logic [31:0] a_ret);
        string p;
        p = (k == 0) ? "u0" : "u1";
        chk({p, ".insn"},          64'(a_insn),  64'(m_insn[k]));
        chk({p, ".start"},         64'(a_start), 64'(m_start[k]));
        chk({p, ".memory_start"},  64'(a_ms),    64'(m_ph[k] == PH_FETCH));
        chk({p, ".sel_mem_fetch"}, 64'(a_sel),   64'(m_ph[k] == PH_FETCH || m_ph[k] == PH_WAIT));
        chk({p, ".busy"},          64'(a_busy),  64'(m_ph[k] != PH_IDLE && m_ph[k] != PH_TRAP));
        chk({p, ".illegal_insn"},  64'(a_ill),   64'(m_ill[k]));
        chk({p, ".timeout"},       64'(a_to),    64'(m_to[k]));
        chk({p, ".retired"},       64'(a_ret),   64'(m_ret[k]));
    endtask

    // Every-cycle comparison, well clear of the active edge.
    always @(posedge clk) begin
        #2;
        cmp_one(0, insn0, start0, ms0, sel0, busy0, ill0, to0, {28'd0, ret0});
        cmp_one(1, insn1, start1, ms1, sel1, busy1, ill1, to1, ret1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".start"},   64'(start0), 64'd0);
        chk({tag, ".busy"},    64'(busy0),  64'd0);
        chk({tag, ".mstart"},  64'(ms0),    64'd0);
        chk({tag, ".sel"},     64'(sel0),   64'd0);
        chk({tag, ".insn"},    64'(insn0),  64'd0);
        chk({tag, ".retired"}, 64'(ret0),   64'd0);
        chk({tag, ".illegal"}, 64'(ill0),   64'd0);
        chk({tag, ".timeout"}, 64'(to0),    64'd0);
    endtask

    // Entered at a negedge while in FETCH; executes for n cycles, done on the n-th.
    task automatic exec_insn(input logic [31:0] rdata, input int n, input logic [2:0] exp_start);
        cyc(1);
        mem_rdata = rdata; memory_done = 1'b1;
        cyc(1);
        memory_done = 1'b0;
        cyc(1);
        for (int i = 1; i <= n; i++) begin
            chk("exec.start_held", 64'(start0), 64'(exp_start));
            chk("exec.no_fetch",   64'(ms0),    64'd0);
            if (i == n) done = 1'b1;
            cyc(1);
        end
        done = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        int mode;
        logic [31:0] r;

        // Reset state
        cyc(3);
        chk_reset_vals("reset");
        chk("reset.u1.retired", 64'(ret1), 64'd0);

        // 1: first fetch, first ALU instruction
        run = 1'b1; reset_n = 1'b1;
        cyc(1);
        chk("t1.mstart", 64'(ms0), 64'd1);
        chk("t1.sel",    64'(sel0), 64'd1);
        mem_rdata = 32'h0000_007F; memory_done = 1'b1;   // ignored in FETCH
        cyc(1);
        chk("t1.wait_mstart", 64'(ms0), 64'd0);
        chk("t1.wait_insn",   64'(insn0), 64'd0);
        mem_rdata = 32'h00A0_0093;
        cyc(1);
        memory_done = 1'b0;
        chk("t1.insn", 64'(insn0), 64'h00A0_0093);
        chk("t1.start_decode", 64'(start0), 64'd0);
        cyc(1);
        chk("t1.start", 64'(start0), 64'b001);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("t1.retired", 64'(ret0), 64'd1);
        chk("t1.refetch", 64'(ms0), 64'd1);

        // 2: branch then load, 5-cycle execute each
        exec_insn(32'h0020_8463, 5, 3'b010);
        exec_insn(32'h0000_A103, 5, 3'b100);
        chk("t2.retired", 64'(ret0), 64'd3);

        // 5: run dropped during EXEC
        run = 1'b0;
        exec_insn(32'h0010_0013, 3, 3'b001);
        chk("t5.idle_busy", 64'(busy0), 64'd0);
        cyc(2);
        chk("t5.idle_mstart", 64'(ms0), 64'd0);
        chk("t5.retired", 64'(ret1), 64'd4);
        run = 1'b1;
        cyc(1);
        chk("t5.resume", 64'(ms0), 64'd1);

        // 3: illegal opcode trap
        cyc(1);
        mem_rdata = 32'h0000_007F; memory_done = 1'b1;
        cyc(1);
        memory_done = 1'b0;
        cyc(1);
        chk("t3.illegal", 64'(ill0), 64'd1);
        chk("t3.busy",    64'(busy0), 64'd0);
        chk("t3.start",   64'(start0), 64'd0);
        memory_done = 1'b1; done = 1'b1; mem_rdata = 32'h0000_0013;
        cyc(3);
        memory_done = 1'b0; done = 1'b0;
        chk("t3.insn_kept", 64'(insn0), 64'h0000_007F);
        chk("t3.retired",   64'(ret0), 64'd4);
        chk("t3.still_trap", 64'(busy1), 64'd0);

        // 6a: async reset out of TRAP, then mid-WAIT
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("t6.trap_rst");
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("t6.in_wait", 64'(sel0), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("t6.wait_rst");
        cyc(1);
        reset_n = 1'b1;
        cyc(1);

        // 6b: async reset mid-EXEC
        cyc(1);
        mem_rdata = 32'h0000_0033; memory_done = 1'b1;
        cyc(1);
        memory_done = 1'b0;
        cyc(1);
        chk("t6.exec_start", 64'(start0), 64'b001);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("t6.exec_rst");
        chk("t6.exec_rst.u1start", 64'(start1), 64'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);

        // 4: watchdog expiry on u0, u1 keeps waiting
        cyc(1);
        mem_rdata = 32'h0000_0063; memory_done = 1'b1;
        cyc(1);
        memory_done = 1'b0;
        cyc(1);
        cyc(7);
        chk("t4.cycle8_start", 64'(start0), 64'b010);
        chk("t4.cycle8_to",    64'(to0), 64'd0);
        cyc(1);
        chk("t4.timeout", 64'(to0), 64'd1);
        chk("t4.start",   64'(start0), 64'd0);
        chk("t4.busy",    64'(busy0), 64'd0);
        chk("t4.u1_busy", 64'(busy1), 64'd1);
        chk("t4.u1_start", 64'(start1), 64'b010);
        pulse_reset();
        exec_insn(32'h0000_0013, 8, 3'b001);
        chk("t4.no_trap",  64'(to0), 64'd0);
        chk("t4.retired",  64'(ret0), 64'd1);

        // 6c: counter wrap on the 4-bit instance
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            r = {$urandom()} & 32'hFFFF_FF80;
            r[6:0] = pick_legal();
            exec_insn(r, 1 + int'($urandom_range(0, 2)), classify(r[6:0]));
        end
        chk("t6.wrap_u0", 64'(ret0), 64'd0);
        chk("t6.wrap_u1", 64'(ret1), 64'd16);

        // Random traffic
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) mode = int'($urandom_range(0, 2));
            run = ($urandom_range(0, 9) != 0);
            memory_done = ($urandom_range(0, 2) == 0);
            done = (mode == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) == 0);
            r = $urandom();
            if ($urandom_range(0, 15) != 0) r[6:0] = pick_legal();
            mem_rdata = r;
            if ((m_ph[0] == PH_TRAP && m_ph[1] == PH_TRAP) || $urandom_range(0, 149) == 0) begin
                #($urandom_range(1, 4)) reset_n = 1'b0;
                cyc(1);
                reset_n = 1'b1;
            end else begin
                cyc(1);
            end
        end
        run = 1'b0; memory_done = 1'b0; done = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
